// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory boot loader
// Loader state encoding, the NOP word and default geometry.
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

  localparam logic [15:0] NOP_WORD      = 16'h0000;
  localparam int          DEFAULT_DEPTH = 256;
  localparam int          DEFAULT_AW    = 8;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - boot image word stream (valid/ready) between loader source and memory
// The source drives valid/data/last; the memory block answers with ready.
interface imem_boot_loader_if;

  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x 16 instruction storage, synchronous write, asynchronous read
// Contents are deliberately not reset so a reload can leave untouched words intact.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - instruction memory with boot-load FSM holding the core until the image is in
// LOAD fills the array from the word stream; RUN serves combinational reads at IMAddress.
module imem_boot_loader #(
  parameter int          DEPTH    = imem_pkg::DEFAULT_DEPTH,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [15:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   load,
  input  logic                reload,
  input  logic [15:0]         IMAddress,
  output logic [15:0]         instr,
  output logic                core_hold,
  output logic [AW:0]         words_loaded
);

  import imem_pkg::*;

  loader_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          we;
  logic [15:0]   rdata;
  logic          in_range;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    cnt_d           = cnt_q;
    we              = 1'b0;
    load.load_ready = (state_q == LOAD);
    core_hold       = (state_q == LOAD);
    unique case (state_q)
      LOAD: begin
        if (load.load_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q + (AW+1)'(1);
          // Filling the last slot ends the image even without load_last.
          if (load.load_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (load.load_data),
    .raddr (IMAddress[AW-1:0]),
    .rdata (rdata)
  );

  // Full 16-bit compare so high address bits never alias into the array.
  assign in_range     = ({1'b0, IMAddress} < 17'(DEPTH));
  assign instr        = ((state_q == RUN) && in_range) ? rdata : NOP_WORD;
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed scoreboard bench for imem_boot_loader at DEPTH 256 and DEPTH 4
// A reference model tracks state, pointer, count and memory image per instance.
module tb_imem_boot_loader;

  import imem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_boot_loader_if la ();
  imem_boot_loader_if lb ();

  logic        reload_a, reload_b;
  logic [15:0] addr_a, addr_b;
  logic [15:0] instr_a, instr_b;
  logic        hold_a, hold_b;
  logic [8:0]  wl_a;
  logic [2:0]  wl_b;

  imem_boot_loader #(.DEPTH(256)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .load         (la),
    .reload       (reload_a),
    .IMAddress    (addr_a),
    .instr        (instr_a),
    .core_hold    (hold_a),
    .words_loaded (wl_a)
  );

  imem_boot_loader #(.DEPTH(4)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .load         (lb),
    .reload       (reload_b),
    .IMAddress    (addr_b),
    .instr        (instr_b),
    .core_hold    (hold_b),
    .words_loaded (wl_b)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t           sb_q[$];
  int            vectors     = 0;
  int            miscompares = 0;

  loader_state_t mst[2];
  int            mptr[2];
  int            mcnt[2];
  logic [15:0]   mmem[2][256];
  int            mdepth[2] = '{256, 4};

  task automatic sb_push(string tag, logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(logic [15:0] obs);
    sb_t e;
    e = sb_q.pop_front();
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic model_edge(int s, logic v, logic [15:0] d, logic l, logic r);
    if (!reset) begin
      mst[s]  = LOAD;
      mptr[s] = 0;
      mcnt[s] = 0;
    end else if (mst[s] == LOAD) begin
      if (v) begin
        mmem[s][mptr[s]] = d;
        if (l || mptr[s] == mdepth[s] - 1) mst[s] = RUN;
        mptr[s] = (mptr[s] + 1) % mdepth[s];
        mcnt[s] = mcnt[s] + 1;
      end
    end else if (r) begin
      mst[s]  = LOAD;
      mptr[s] = 0;
      mcnt[s] = 0;
    end
  endtask

  task automatic step(int sel, logic v, logic [15:0] d, logic l, logic r);
    la.load_valid = (sel == 0) && v;
    la.load_data  = d;
    la.load_last  = l;
    reload_a      = (sel == 0) && r;
    lb.load_valid = (sel == 1) && v;
    lb.load_data  = d;
    lb.load_last  = l;
    reload_b      = (sel == 1) && r;
    @(posedge clk);
    model_edge(0, (sel == 0) && v, d, l, (sel == 0) && r);
    model_edge(1, (sel == 1) && v, d, l, (sel == 1) && r);
    #1;
    la.load_valid = 1'b0;
    lb.load_valid = 1'b0;
    reload_a      = 1'b0;
    reload_b      = 1'b0;
  endtask

  function automatic logic [15:0] exp_instr(int s, logic [15:0] a);
    if (mst[s] != RUN || int'(a) >= mdepth[s]) return NOP_WORD;
    return mmem[s][int'(a)];
  endfunction

  task automatic status(int s, string tag);
    logic [15:0] a;
    a = (s == 0) ? addr_a : addr_b;
    sb_push({tag, ".load_ready"},   {15'd0, mst[s] == LOAD});
    sb_push({tag, ".core_hold"},    {15'd0, mst[s] == LOAD});
    sb_push({tag, ".words_loaded"}, 16'(mcnt[s]));
    sb_push({tag, ".instr"},        exp_instr(s, a));
    if (s == 0) begin
      chk({15'd0, la.load_ready});
      chk({15'd0, hold_a});
      chk({7'd0, wl_a});
      chk(instr_a);
    end else begin
      chk({15'd0, lb.load_ready});
      chk({15'd0, hold_b});
      chk({13'd0, wl_b});
      chk(instr_b);
    end
  endtask

  task automatic read(int s, logic [15:0] a, string tag);
    if (s == 0) addr_a = a; else addr_b = a;
    #1;
    sb_push($sformatf("%s.instr@%h", tag, a), exp_instr(s, a));
    chk((s == 0) ? instr_a : instr_b);
  endtask

  initial begin
    reset = 1'b0;
    addr_a = '0;
    addr_b = '0;
    la.load_data = '0; la.load_last = 1'b0;
    lb.load_data = '0; lb.load_last = 1'b0;

    step(0, 0, 16'h0, 0, 0);
    step(0, 0, 16'h0, 0, 0);
    reset = 1'b1;
    step(0, 0, 16'h0, 0, 0);
    status(0, "rst_a");
    status(1, "rst_b");

    step(0, 1, 16'hA001, 0, 0);
    step(0, 1, 16'hA002, 0, 0);
    status(0, "mid_a");
    step(0, 1, 16'hA003, 1, 0);
    status(0, "run_a");
    for (int i = 0; i < 3; i++) read(0, 16'(i), "img_a");
    read(0, 16'h0100, "oor_a");
    addr_a = '0;
    step(0, 1, 16'h7777, 0, 0);
    status(0, "runval_a");

    for (int i = 0; i < 6; i++) begin
      step(1, 1, 16'hE000 + 16'(i), 0, 0);
      status(1, $sformatf("fill_b%0d", i));
    end
    for (int i = 0; i < 4; i++) read(1, 16'(i), "full_b");
    read(1, 16'h0004, "oor_b");
    read(1, 16'hFFFF, "oor_b");
    addr_b = '0;

    step(1, 0, 16'h0, 0, 1);
    status(1, "reload_b");
    step(1, 1, 16'hF001, 0, 0);
    step(1, 0, 16'hF0FF, 0, 0);
    status(1, "gap_b");
    step(1, 1, 16'hF002, 0, 0);
    step(1, 0, 16'hF0FE, 1, 0);
    status(1, "gap2_b");
    step(1, 1, 16'hF003, 1, 0);
    status(1, "done_b");
    for (int i = 0; i < 4; i++) read(1, 16'(i), "toggle_b");

    addr_a = '0;
    step(0, 0, 16'h0, 0, 1);
    status(0, "reload_a");
    step(0, 0, 16'h0, 0, 1);
    status(0, "reload_in_load_a");
    step(0, 1, 16'hBEEF, 1, 0);
    status(0, "beef_a");
    read(0, 16'h0000, "beef_a");
    read(0, 16'h0001, "keep_a");

    addr_a = '0;
    step(0, 0, 16'h0, 0, 1);
    step(0, 1, 16'hC001, 0, 0);
    step(0, 1, 16'hC002, 0, 0);
    reset = 1'b0;
    step(0, 0, 16'h0, 0, 0);
    reset = 1'b1;
    status(0, "midrst_a");
    status(1, "midrst_b");
    step(0, 1, 16'hD001, 1, 0);
    status(0, "fresh_a");
    for (int i = 0; i < 3; i++) read(0, 16'(i), "fresh_a");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
